fft_sdf_stage: RTL and testbench
================================

Name: fft_sdf_stage

Overview:
- Parametrised radix-2 decimation-in-frequency butterfly stage, single-path delay-feedback (SDF) style, streaming one complex sample per accepted beat.
- Generalises the fixed first stage: any span (stage position), any frame length, valid/sop framing with gaps, forward/inverse mode, optional 1/2 scaling, and a sticky overflow flag.
- Cascaded LOG2N times between the input formatter and the bit-reverse reorder buffer, with SPAN_LOG2 decreasing from LOG2N-1 to 0.

Parameters:
- DBW, 8, width of each real/imag component; two's complement; twiddles are s1.DBW-2 (1.0 = 2^(DBW-2)).
- LOG2N, 4, log2 of frame length N.
- SPAN_LOG2, LOG2N-1, log2 of butterfly span S; delay buffer depth S; legal range 0..LOG2N-1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  din accepted this cycle.
- in_sop  in  1  qualifies in_valid; first sample of a frame.
- din  in  2*DBW  sample, {im, re}.
- trigon  in  2*DBW*(N/2)  twiddle table; entry k at bits [2*DBW*k +: 2*DBW], {im, re}; W^k = exp(-j2πk/N).
- inverse  in  1  1 = use conj(W); sampled per beat.
- scale  in  1  1 = halve sum and difference before use; sampled per beat.
- ovf_clr  in  1  clears ovf.
- out_valid  out  1  dout valid.
- out_sop  out  1  first output sample of a frame.
- dout  out  2*DBW  result, {im, re}.
- ovf  out  1  sticky saturation flag.

Behaviour:
- Reset values: pos=0, primed=0, out_valid=0, out_sop=0, dout=0, ovf=0. The delay buffer is not reset.
- pos (LOG2N bits) advances by 1 per accepted beat and wraps at N. An accepted beat with in_sop forces that beat to pos=0.
- Within each 2S block, phase = pos[SPAN_LOG2]; k = pos[SPAN_LOG2-1:0]; buffer slot = k.
- Phase 0:
  - Buffer slot k is written with din (a_k).
  - The previously stored y_k is emitted.
- Phase 1, with b_k = din and a_k from the buffer:
  - Emit x_k = a_k + b_k.
  - Write y_k = (a_k - b_k) * W^(k << (LOG2N-1-SPAN_LOG2)) into slot k.
- Sum/difference are computed at DBW+1 bits. If scale=1, they become (v+1)>>>1. Both then saturate to DBW bits.
- Multiply:
  - Full-precision complex product.
  - Twiddle imag is negated when inverse=1.
  - Round half-up: add 2^(DBW-3), then >>> (DBW-2).
  - Saturate to DBW bits.
- Any saturation on a beat that drives a valid output or buffer write sets ovf.
- ovf_clr clears ovf. If set and clear occur in the same cycle, ovf ends at 1.
- Latency: dout/out_valid is registered, 1 clk after the accepted beat that produced it. out_valid = previous in_valid & primed.
- Output order per 2S block: x_0..x_(S-1), then y_0..y_(S-1). Output lags input by S accepted beats.
- primed sets after the first S accepted beats following reset or an abort.
- out_sop is asserted with the output produced by the beat at pos==S.
- Gaps (in_valid=0):
  - No state changes.
  - out_valid=0 next cycle.
  - dout holds its last value.
- Tail: the last S outputs of a frame (its final y's) leave only when the next S beats are accepted. Upstream sends the next frame or zero-padding.
- in_sop with pos≠0 (abort):
  - pos restarts at 0 and primed clears.
  - No outputs until re-primed; stale buffer contents are never emitted.
  - ovf is unaffected.
- in_sop at pos==0: normal continuation.
- Async reset mid-frame: all registers return to reset values immediately; buffer contents are ignored afterward.
- SPAN_LOG2=0: S=1, a single register buffer, twiddle index k<<(LOG2N-1) is always 0.

Test Plan:
Setup for all: DBW=8, LOG2N=3, SPAN_LOG2=2, W0=(re64,im0), W1=(45,-45), W2=(0,-64), W3=(-45,-45).
- Impulse: frame re=[16,0,0,0,0,0,0,0], im=0, scale=0, then 4 zero beats -> dout re = 16,0,0,0,16,0,0,0, im all 0; out_sop on first; first out_valid 1 clk after beat 4.
- DC: 8 beats re=10, then 4 zero beats -> scale=0: x=20 ×4, y=0 ×4; scale=1: x=10 ×4, y=0 ×4; ovf stays 0.
- Twiddle rounding: a_1=0, b_1=(re -32, im 0) -> y_1=(23,-22); with inverse=1 -> y_1=(23,23).
- Saturation: a_0=b_0=(127,0), scale=0 -> x_0 re=127, ovf=1; ovf_clr pulse -> ovf=0; repeat with scale=1 -> x_0=127, ovf stays 0; ovf_clr and saturation in same cycle -> ovf=1.
- Gaps: impulse frame with in_valid toggling every other cycle -> same 8 output values, out_valid on alternate cycles, dout held during gaps.
- Abort/reset: in_sop at pos=5 -> no out_valid until 4 new beats accepted; rst_n low mid-frame -> out_valid, out_sop, dout, ovf all 0 asynchronously.

Source files
------------

// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage with span 2^SPAN_LOG2.
// Streams one {im, re} sample per accepted beat; saturating arithmetic with a sticky overflow flag.
module fft_sdf_stage #(
    parameter int DBW       = 8,
    parameter int LOG2N     = 4,
    parameter int SPAN_LOG2 = LOG2N - 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic                                   in_sop,
    input  logic [2*DBW-1:0]                       din,
    input  logic [2*DBW*(1 << (LOG2N-1))-1:0]      trigon,
    input  logic                                   inverse,
    input  logic                                   scale,
    input  logic                                   ovf_clr,
    output logic                                   out_valid,
    output logic                                   out_sop,
    output logic [2*DBW-1:0]                       dout,
    output logic                                   ovf
);
    localparam int N     = 1 << LOG2N;
    localparam int S     = 1 << SPAN_LOG2;
    localparam int KW    = (SPAN_LOG2 > 0) ? SPAN_LOG2 : 1;
    localparam int DEPTH = 1 << KW;
    localparam int TIW   = LOG2N - 1;
    localparam int SH    = LOG2N - 1 - SPAN_LOG2;
    localparam int WW    = 2*DBW + 2;
    localparam logic signed [WW-1:0] RND = WW'(1 << (DBW-3));

    logic [LOG2N-1:0]         pos_reg, pos_eff;
    logic                     primed_reg, primed_eff, abort, phase;
    logic                     out_valid_reg, out_sop_reg, ovf_reg, ovf_set;
    logic [2*DBW-1:0]         dout_reg;
    logic [KW-1:0]            k;
    logic [TIW-1:0]           tw_idx;
    logic [2*DBW-1:0]         mem [DEPTH];
    logic [2*DBW-1:0]         a_word, x_word, y_word;
    logic signed [DBW-1:0]    a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [DBW-1:0]    x_re, x_im, dq_re, dq_im, y_re, y_im;
    logic signed [DBW-1:0]    tw_re [N/2];
    logic signed [DBW-1:0]    tw_im [N/2];
    logic signed [WW-1:0]     s_re, s_im, d_re, d_im, w_im_eff, p_re, p_im, q_re, q_im;

    function automatic logic signed [WW-1:0] halve(input logic signed [WW-1:0] v, input logic en);
        logic signed [WW-1:0] t;
        t = v + WW'(1);
        return en ? (t >>> 1) : v;
    endfunction

    function automatic logic sat_hit(input logic signed [WW-1:0] v);
        return !((&v[WW-1:DBW-1]) || !(|v[WW-1:DBW-1]));
    endfunction

    function automatic logic [DBW-1:0] sat(input logic signed [WW-1:0] v);
        if (sat_hit(v))
            return v[WW-1] ? {1'b1, {(DBW-1){1'b0}}} : {1'b0, {(DBW-1){1'b1}}};
        return v[DBW-1:0];
    endfunction

    for (genvar gi = 0; gi < N/2; gi++) begin : g_tw
        assign tw_re[gi] = trigon[2*DBW*gi +: DBW];
        assign tw_im[gi] = trigon[2*DBW*gi + DBW +: DBW];
    end

    // A start-of-frame beat always lands at position 0; mid-frame it also drops priming.
    assign abort      = in_valid && in_sop && (pos_reg != '0);
    assign pos_eff    = (in_valid && in_sop) ? '0 : pos_reg;
    assign primed_eff = abort ? 1'b0 : primed_reg;
    assign phase      = pos_eff[SPAN_LOG2];

    // With S=1 only slot 0 is ever addressed.
    if (SPAN_LOG2 == 0) begin : g_k1
        assign k = 1'b0;
    end else begin : g_kn
        assign k = pos_eff[SPAN_LOG2-1:0];
    end
    assign tw_idx = TIW'(k) << SH;

    // Buffer read is combinational so the butterfly completes in the accepting beat.
    assign a_word = mem[k];
    assign a_re   = a_word[DBW-1:0];
    assign a_im   = a_word[2*DBW-1:DBW];
    assign b_re   = din[DBW-1:0];
    assign b_im   = din[2*DBW-1:DBW];
    assign w_re   = tw_re[tw_idx];
    assign w_im   = tw_im[tw_idx];

    assign s_re  = halve(WW'(a_re) + WW'(b_re), scale);
    assign s_im  = halve(WW'(a_im) + WW'(b_im), scale);
    assign d_re  = halve(WW'(a_re) - WW'(b_re), scale);
    assign d_im  = halve(WW'(a_im) - WW'(b_im), scale);
    assign x_re  = sat(s_re);
    assign x_im  = sat(s_im);
    assign dq_re = sat(d_re);
    assign dq_im = sat(d_im);

    assign w_im_eff = inverse ? -WW'(w_im) : WW'(w_im);
    assign p_re     = WW'(dq_re) * WW'(w_re) - WW'(dq_im) * w_im_eff + RND;
    assign p_im     = WW'(dq_re) * w_im_eff + WW'(dq_im) * WW'(w_re) + RND;
    assign q_re     = p_re >>> (DBW-2);
    assign q_im     = p_im >>> (DBW-2);
    assign y_re     = sat(q_re);
    assign y_im     = sat(q_im);

    assign x_word  = {x_im, x_re};
    assign y_word  = {y_im, y_re};
    // Phase-1 beats always write the buffer, so any clipping there counts.
    assign ovf_set = in_valid && phase &&
                     (sat_hit(s_re) || sat_hit(s_im) || sat_hit(d_re) || sat_hit(d_im) ||
                      sat_hit(q_re) || sat_hit(q_im));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg       <= '0;
            primed_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sop_reg   <= 1'b0;
            dout_reg      <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            ovf_reg       <= ovf_set || (ovf_reg && !ovf_clr);
            out_valid_reg <= in_valid && primed_eff;
            out_sop_reg   <= in_valid && primed_eff && (pos_eff == LOG2N'(S));
            if (in_valid) begin
                pos_reg    <= pos_eff + 1'b1;
                primed_reg <= primed_eff || (pos_eff == LOG2N'(S-1));
                if (primed_eff)
                    dout_reg <= phase ? x_word : a_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid)
            mem[k] <= phase ? y_word : din;
    end

    assign out_valid = out_valid_reg;
    assign out_sop   = out_sop_reg;
    assign dout      = dout_reg;
    assign ovf       = ovf_reg;
endmodule

// File: tb/tb_fft_sdf_stage.sv
// Bench for fft_sdf_stage (N=8, S=4): directed frames feed a queue of expected outputs,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_fft_sdf_stage;
    localparam int DBW = 8, LOG2N = 3, SPAN_LOG2 = 2;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_sop, inverse, scale, ovf_clr;
    logic [15:0] din, dout;
    logic [63:0] trigon;
    logic        out_valid, out_sop, ovf;

    int          checks = 0, errors = 0;
    logic [16:0] exp_q [$];
    logic [16:0] e_mon;
    logic [15:0] prev_dout;
    bit          primed_tb, gap_chk;
    int          f_re [8], f_im [8];
    int          xr [4], xi [4], yr [4], yi [4], py_r [4], py_i [4];

    fft_sdf_stage #(.DBW(DBW), .LOG2N(LOG2N), .SPAN_LOG2(SPAN_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .din(din),
        .trigon(trigon), .inverse(inverse), .scale(scale), .ovf_clr(ovf_clr),
        .out_valid(out_valid), .out_sop(out_sop), .dout(dout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input bit sop, input int re, input int im);
        exp_q.push_back({sop, 8'(im), 8'(re)});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dout = '0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got re=%0d im=%0d, expected none",
                             $signed(dout[7:0]), $signed(dout[15:8]));
                end else begin
                    e_mon = exp_q.pop_front();
                    check("out_sop", int'(out_sop), int'(e_mon[16]));
                    check("dout_re", int'($signed(dout[7:0])), int'($signed(e_mon[7:0])));
                    check("dout_im", int'($signed(dout[15:8])), int'($signed(e_mon[15:8])));
                    $display("out re=%0d im=%0d sop=%0d", $signed(dout[7:0]), $signed(dout[15:8]), out_sop);
                end
            end else if (gap_chk) begin
                check("dout_hold", int'(dout), int'(prev_dout));
            end
            prev_dout = dout;
        end
    end

    task automatic beat(input int re, input int im, input bit sop, input bit sc, input bit inv, input bit clr);
        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        din      = {8'(im), 8'(re)};
        scale    = sc;
        inverse  = inv;
        ovf_clr  = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sop   = 1'b0;
            ovf_clr  = 1'b0;
        end
    endtask

    // One full frame: beats 0..3 emit the previous frame's y, beats 4..7 emit this frame's x.
    task automatic run_frame(input bit sc, input bit inv, input int clr_beat, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (i < 4 && primed_tb) push_exp(1'b0, py_r[i], py_i[i]);
            if (i >= 4) push_exp(i == 4, xr[i-4], xi[i-4]);
            beat(f_re[i], f_im[i], i == 0, sc, inv, i == clr_beat);
            if (gaps) idle(1);
        end
        py_r = yr;
        py_i = yi;
        primed_tb = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; din = '0;
        inverse = 1'b0; scale = 1'b0; ovf_clr = 1'b0;
        trigon = 64'hD3D3_C000_D32D_0040;
        primed_tb = 1'b0; gap_chk = 1'b0;
        f_im = '{default:0}; xi = '{default:0}; yi = '{default:0};
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sop", int'(out_sop), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;

        // impulse
        f_re = '{16,0,0,0,0,0,0,0}; xr = '{16,0,0,0}; yr = '{16,0,0,0};
        run_frame(0, 0, -1, 0);
        // DC, unscaled then scaled
        f_re = '{default:10}; xr = '{default:20}; yr = '{default:0};
        run_frame(0, 0, -1, 0);
        xr = '{default:10};
        run_frame(1, 0, -1, 0);
        // twiddle rounding, forward then inverse
        f_re = '{0,0,0,0,0,-32,0,0}; xr = '{0,-32,0,0}; yr = '{0,23,0,0}; yi = '{0,-22,0,0};
        run_frame(0, 0, -1, 0);
        yi = '{0,23,0,0};
        run_frame(0, 1, -1, 0);
        idle(1);
        check("ovf_no_sat", int'(ovf), 0);

        // saturation
        f_re = '{127,0,0,0,127,0,0,0}; xr = '{127,0,0,0}; yr = '{default:0}; yi = '{default:0};
        run_frame(0, 0, -1, 0);
        idle(1);
        check("ovf_set", int'(ovf), 1);
        @(negedge clk); in_valid = 1'b0; ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        check("ovf_cleared", int'(ovf), 0);
        run_frame(1, 0, -1, 0);
        idle(1);
        check("ovf_scaled", int'(ovf), 0);
        run_frame(0, 0, 4, 0);
        idle(1);
        check("ovf_set_wins", int'(ovf), 1);

        // impulse with gaps, then a zero frame to flush its y's
        f_re = '{16,0,0,0,0,0,0,0}; xr = '{16,0,0,0}; yr = '{16,0,0,0};
        gap_chk = 1'b1;
        run_frame(0, 0, -1, 1);
        gap_chk = 1'b0;
        f_re = '{default:0}; xr = '{default:0}; yr = '{default:0};
        run_frame(0, 0, -1, 0);

        // abort at pos 5
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, py_r[i], py_i[i]);
            beat(7, 0, i == 0, 0, 0, 0);
        end
        push_exp(1'b1, 14, 0);
        beat(7, 0, 0, 0, 0, 0);
        beat(3, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) beat(0, 0, 0, 0, 0, 0);
        push_exp(1'b1, 8, 0);
        beat(5, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 0, 0);
            beat(0, 0, 0, 0, 0, 0);
        end
        py_r = '{-2,0,0,0}; py_i = '{default:0};
        idle(1);
        check("ovf_after_abort", int'(ovf), 1);

        // asynchronous reset mid-frame
        push_exp(1'b0, -2, 0);
        beat(9, 0, 1, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0;
        check("valid_before_reset", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_sop", int'(out_sop), 0);
        check("arst_dout", int'(dout), 0);
        check("arst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        primed_tb = 1'b0;
        f_re = '{16,0,0,0,0,0,0,0}; xr = '{16,0,0,0}; yr = '{16,0,0,0};
        run_frame(0, 0, -1, 0);
        f_re = '{default:0}; xr = '{default:0}; yr = '{default:0};
        run_frame(0, 0, -1, 0);
        idle(4);
        check("pending_outputs", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
